// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  timer_pkg : shared types and constants for the timer run controller
//  Rev 1.0
// ============================================================================
package timer_pkg;

    localparam int TIMER_WIDTH = 28;
    localparam int CLK_HZ      = 100_000_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } timer_state_t;

    // Terminal count giving an expiry rate of hz with the given prescale.
    function automatic logic [TIMER_WIDTH-1:0] period_for_hz(
        input int unsigned hz,
        input int unsigned prescale
    );
        return TIMER_WIDTH'(CLK_HZ / (hz * prescale));
    endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_if.sv
`default_nettype none
// ============================================================================
//  timer_if : control/status bundle between a timer user and timer_ctrl
//  Rev 1.0
// ============================================================================
interface timer_if #(
    parameter int WIDTH = timer_pkg::TIMER_WIDTH
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             periodic;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, stop, pause, periodic, period,
        input  count, busy, done, err
    );

    modport slave (
        input  start, stop, pause, periodic, period,
        output count, busy, done, err
    );
endinterface : timer_if
`default_nettype wire

// File: rtl/timer_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  tick_prescaler : divides enabled clocks by PRESCALE, one-cycle tick out
//  Rev 1.0
// ============================================================================
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_en,
    input  wire logic i_clr,
    output logic      o_tick
);
    localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] C_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == C_LAST);

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
//  timer_ctrl : start/pause/stop run controller for a terminal-count timer
//  Rev 1.0
// ============================================================================
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH    = TIMER_WIDTH,
    parameter int PRESCALE = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    timer_if.slave    bus
);
    timer_state_t     r_state;
    timer_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;
    logic             r_periodic;
    logic             r_done;
    logic             r_busy;
    logic             r_err;

    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_period_nxt;
    logic             w_periodic_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;

    logic w_start_ok;
    logic w_start_bad;
    logic w_active;
    logic w_adv;
    logic w_tick;
    logic w_expire;

    assign w_start_ok  = bus.start && !bus.stop && (bus.period != '0);
    assign w_start_bad = bus.start && !bus.stop && (bus.period == '0);
    assign w_active    = (r_state == ST_RUN) || (r_state == ST_HOLD);
    // A HOLD edge with pause low already advances, so each paused edge costs one clock.
    assign w_adv       = w_active && !bus.stop && !w_start_ok && !bus.pause;
    assign w_expire    = w_tick && (r_count == r_period - WIDTH'(1));

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_adv),
        .i_clr  (bus.stop || w_start_ok),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.stop) begin
            w_state_nxt = ST_IDLE;
        end else if (w_start_ok) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN, ST_HOLD: begin
                    if (bus.pause) begin
                        w_state_nxt = ST_HOLD;
                    end else if (w_expire && !r_periodic) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_count_nxt    = r_count;
        w_period_nxt   = r_period;
        w_periodic_nxt = r_periodic;
        w_done_nxt     = 1'b0;
        w_err_nxt      = r_err;
        if (bus.stop) begin
            w_count_nxt = '0;
        end else if (w_start_ok) begin
            w_count_nxt    = '0;
            w_period_nxt   = bus.period;
            w_periodic_nxt = bus.periodic;
            w_err_nxt      = 1'b0;
        end else begin
            if (w_start_bad) begin
                w_err_nxt = 1'b1;
            end
            if (w_expire) begin
                w_done_nxt  = 1'b1;
                w_count_nxt = r_periodic ? '0 : r_count;
            end else if (w_tick) begin
                w_count_nxt = r_count + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_period   <= '0;
            r_periodic <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_period   <= w_period_nxt;
            r_periodic <= w_periodic_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HOLD);
            r_err      <= w_err_nxt;
        end
    end

    assign bus.count = r_count;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.err   = r_err;

endmodule : timer_ctrl
`default_nettype wire
